// File: rtl/pack_s3_ctrl.sv
// pack_s3_ctrl: sequences packing of one hash block, word by word, driving two trit5_to_bit8 converters and a SIPO.
// Optional abort input is enabled by defining PACK_S3_CTRL_ABORT_EN.
module pack_s3_ctrl #(
    parameter int WORDS  = 68,
    parameter int PHASES = 4
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       start,
`ifdef PACK_S3_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic [6:0] word_idx,
    output logic [1:0] count,
    output logic       conv_rst,
    output logic       sipo_clr,
    output logic       shift_en,
    output logic       stop,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, CLR, CONV, SHIFT, DONE} state_t;

    localparam logic [6:0] LAST_WORD  = 7'(WORDS - 1);
    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    state_t     state_q, state_d;
    logic [6:0] word_idx_q, word_idx_d;
    logic [1:0] count_q, count_d;
    logic       conv_rst_q, conv_rst_d;
    logic       sipo_clr_q, sipo_clr_d;
    logic       shift_en_q, shift_en_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       abort_hit;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
`ifdef PACK_S3_CTRL_ABORT_EN
        abort_hit  = abort && (state_q != IDLE);
`else
        abort_hit  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CLR;
                    word_idx_d = 7'd0;
                end
            end
            CLR:  state_d = CONV;
            CONV: begin
                if (count_q == LAST_PHASE) state_d = SHIFT;
                else                       count_d = count_q + 2'd1;
            end
            SHIFT: begin
                if (word_idx_q == LAST_WORD) begin
                    state_d = DONE;
                end else begin
                    state_d    = CLR;
                    word_idx_d = word_idx_q + 7'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the sequence wanted, including SHIFT->DONE.
        if (abort_hit) state_d = IDLE;

        // Outputs are decoded from the next state so they are registered alongside it.
        if (state_d == CLR) count_d = 2'd0;
        conv_rst_d = (state_d == CLR);
        sipo_clr_d = ((state_q == IDLE) && (state_d == CLR)) || abort_hit;
        shift_en_d = (state_d == SHIFT);
        stop_d     = (state_d != SHIFT);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= 7'd0;
            count_q    <= 2'd0;
            conv_rst_q <= 1'b1;
            sipo_clr_q <= 1'b1;
            shift_en_q <= 1'b0;
            stop_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            conv_rst_q <= conv_rst_d;
            sipo_clr_q <= sipo_clr_d;
            shift_en_q <= shift_en_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign word_idx = word_idx_q;
    assign count    = count_q;
    assign conv_rst = conv_rst_q;
    assign sipo_clr = sipo_clr_q;
    assign shift_en = shift_en_q;
    assign stop     = stop_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/pack_s3_ctrl.md
PACK_S3_CTRL -- requirements
Module: pack_s3_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 68, meaning the number of 16-bit words per packed hash block (1088/16).
REQ-002 The block SHALL have parameter PHASES, default 4, meaning the number of conversion cycles per word, driven on count 0..PHASES-1.
REQ-003 The block SHALL have port local_clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to pack one block; it is sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel in-flight packing; it is present only with PACK_S3_CTRL_ABORT_EN.
REQ-007 The block SHALL have port word_idx, output, 7 bits: index of the 20-bit rm slice currently converted.
REQ-008 The block SHALL have port count, output, 2 bits: phase counter to both trit5_to_bit8 converters.
REQ-009 The block SHALL have port conv_rst, output, 1 bit: converter reset pulse.
REQ-010 The block SHALL have port sipo_clr, output, 1 bit: SIPO clear pulse (ovr_rst).
REQ-011 The block SHALL have port shift_en, output, 1 bit: SIPO shift qualifier.
REQ-012 The block SHALL have port stop, output, 1 bit: SIPO clock gate, equal to ~shift_en.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 The state machine SHALL have exactly the states IDLE, CLR, CONV, SHIFT and DONE, with all outputs registered.
REQ-016 IDLE with start=1 SHALL transition to CLR and set word_idx=0; sipo_clr=1 only during this first CLR of a block.
REQ-017 CLR SHALL assert conv_rst=1 and count=0 for exactly one cycle, then transition to CONV.
REQ-018 CONV SHALL last PHASES cycles, with count stepping 0,1,2,3, conv_rst=0 and shift_en=0.
REQ-019 CONV SHALL transition to SHIFT after count=PHASES-1.
REQ-020 SHIFT SHALL assert shift_en=1 (stop=0) for exactly one cycle, with word_idx unchanged.
REQ-021 From SHIFT, if word_idx=WORDS-1 the machine SHALL go to DONE; otherwise it SHALL go to CLR with word_idx+1, and sipo_clr SHALL stay 0.
REQ-022 DONE SHALL assert done=1 for one cycle with stop=1, then transition to IDLE.
REQ-023 Each word SHALL take PHASES+2 cycles.
REQ-024 A block SHALL take WORDS*(PHASES+2) cycles; with the defaults, done is high in the 409th cycle after the start-sampling edge.
REQ-025 The number of SIPO shifts per block SHALL be exactly WORDS (68).
REQ-026 start while busy SHALL be ignored, with no queuing.
REQ-027 start sampled in the DONE cycle SHALL be ignored; a new block begins only from IDLE.
REQ-028 word_idx SHALL never exceed WORDS-1 and SHALL not wrap within a block.
REQ-029 count SHALL wrap to 0 on entry to each CLR.
REQ-030 stop SHALL be 1 in IDLE, CLR, CONV and DONE, so that no spurious SIPO shift occurs.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with word_idx=0, count=0, conv_rst=1, sipo_clr=1, shift_en=0, stop=1, busy=0 and done=0.
REQ-032 After rst deasserts, conv_rst and sipo_clr SHALL drop to 0 on the first local_clk edge.
REQ-033 rst mid-block SHALL abandon the block immediately, with no done pulse; the next start SHALL restart from word 0.

Configuration
REQ-034 With PACK_S3_CTRL_ABORT_EN defined, the abort port SHALL exist.
REQ-035 With PACK_S3_CTRL_ABORT_EN defined, abort=1 sampled in any busy state SHALL send the machine to IDLE next cycle, with sipo_clr=1 for that one cycle, done=0 and stop=1.
REQ-036 With PACK_S3_CTRL_ABORT_EN defined, abort SHALL take priority over start and over the SHIFT->DONE transition.
REQ-037 Without PACK_S3_CTRL_ABORT_EN, the abort port SHALL be absent, and a block SHALL always run to DONE unless rst is asserted.

Verification
REQ-038 The bench SHALL check: rst pulse, then start=1 for 1 cycle -> busy=1; sipo_clr pulses once; 68 shift_en pulses spaced 6 cycles apart; done=1 exactly in cycle 409; busy=0 in cycle 410.
REQ-039 The bench SHALL check: during word 5 -> word_idx=5 throughout its CLR, CONV and SHIFT; count sequence 0,0,1,2,3 across CLR then CONV; conv_rst=1 only in CLR.
REQ-040 The bench SHALL check: start held high continuously -> back-to-back blocks separated by DONE plus one IDLE cycle; the second block again shows sipo_clr=1.
REQ-041 The bench SHALL check: start pulsed again at cycle 100 while busy -> ignored; done still in cycle 409; still exactly 68 shifts.
REQ-042 The bench SHALL check: rst asserted asynchronously at cycle 200 -> outputs reach reset values without a clock edge, no done pulse; a later start produces a full 408-cycle block.
REQ-043 The bench SHALL check, with PACK_S3_CTRL_ABORT_EN defined: abort=1 at cycle 150 -> IDLE at cycle 151 with sipo_clr=1, done never asserts, stop=1.
